// File: rtl/fetch_pc_gen_pkg.sv
// Shared constants for the IF-stage fetch PC generator: FSM encodings,
// default bus width and boot address, and pointer sizing.
package fetch_pc_gen_pkg;

  localparam logic [0:0] FPG_BOOT = 1'b0;
  localparam logic [0:0] FPG_RUN  = 1'b1;

  localparam int unsigned  ADDR_BUS = 64;
  localparam logic [63:0]  INIT_PC  = 64'h0000_0000_8000_0000;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned fpg_ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_pc_fifo.sv
// Request/response tracking FIFO: pc captured on issue, inst filled in order
// on response, {pc, inst} popped by decode. Flush empties it in one cycle.
module fetch_pc_fifo
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_BUS,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = fpg_ptr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic              fill,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              pop,
  output logic [PTR_W-1:0]  wr_ptr,
  output logic [PTR_W-1:0]  rsp_ptr,
  output logic [PTR_W-1:0]  rd_ptr,
  output logic              head_valid,
  output logic [ADDR_W-1:0] head_pc,
  output logic [INST_W-1:0] head_inst
);

  localparam int unsigned      IDX_W   = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [INST_W-1:0] inst_mem [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rsp_idx;
  logic [IDX_W-1:0] rd_idx;

  assign wr_idx  = wr_ptr[IDX_W-1:0];
  assign rsp_idx = rsp_ptr[IDX_W-1:0];
  assign rd_idx  = rd_ptr[IDX_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rsp_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (flush) begin
        rsp_ptr <= wr_ptr;
        rd_ptr  <= wr_ptr;
      end else begin
        if (fill) begin
          rsp_ptr <= rsp_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // NOTE: the storage arrays have no reset; the pointers alone decide which
  // slots are live, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_idx] <= push_pc;
    end
    if (fill && !flush) begin
      inst_mem[rsp_idx] <= fill_inst;
    end
  end

  assign head_valid = (rsp_ptr != rd_ptr);
  assign head_pc    = pc_mem[rd_idx];
  assign head_inst  = inst_mem[rd_idx];

endmodule

// File: rtl/fetch_pc_gen.sv
// IF-stage fetch PC generator: issues sequential icache requests, pairs
// in-order responses with their PCs, and squashes stale work on redirect.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W      = ADDR_BUS,
  parameter int unsigned       INST_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC    = INIT_PC[ADDR_W-1:0],
  parameter int unsigned       FETCH_BYTES = 4,
  parameter int unsigned       DEPTH       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              icache_req_valid_o,
  input  logic              icache_req_ready_i,
  output logic [ADDR_W-1:0] icache_req_addr_o,
  input  logic              icache_resp_valid_i,
  input  logic [INST_W-1:0] icache_resp_data_i,
  output logic              inst_valid_o,
  input  logic              inst_ready_i,
  output logic [ADDR_W-1:0] inst_pc_o,
  output logic [INST_W-1:0] inst_o
);

  localparam int unsigned       PTR_W    = fpg_ptr_width(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]    OCC_FULL = (PTR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(FETCH_BYTES);

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [PTR_W-1:0]  drop_cnt;
  logic [PTR_W-1:0]  drop_redirect;
  logic [PTR_W-1:0]  drop_sum;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rsp_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   occ;

  logic issue;
  logic drop_hit;
  logic fill;
  logic pop;

  // Dropped-but-outstanding responses still hold icache bandwidth, so they
  // count against the in-flight budget.
  assign occ = {1'b0, wr_ptr - rd_ptr} + {1'b0, drop_cnt};

  assign icache_req_valid_o = (state == FPG_RUN) && !stall_i && !redirect_valid_i
                              && (occ < OCC_FULL);
  assign icache_req_addr_o  = fetch_pc;

  assign issue    = icache_req_valid_o && icache_req_ready_i;
  assign drop_hit = icache_resp_valid_i && (drop_cnt != '0);
  assign fill     = icache_resp_valid_i && !drop_hit && (wr_ptr != rsp_ptr)
                    && !redirect_valid_i;
  assign pop      = inst_valid_o && inst_ready_i && !redirect_valid_i;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    drop_sum      = drop_cnt + (wr_ptr - rsp_ptr);
    drop_redirect = drop_sum;
    if (icache_resp_valid_i && (drop_sum != '0)) begin
      drop_redirect = drop_sum - PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FPG_BOOT;
      fetch_pc <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state <= FPG_RUN;
      if (redirect_valid_i) begin
        fetch_pc <= redirect_pc_i;
        drop_cnt <= drop_redirect;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (drop_hit) begin
          drop_cnt <= drop_cnt - PTR_ONE;
        end
      end
    end
  end

  fetch_pc_fifo #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (redirect_valid_i),
    .push       (issue),
    .push_pc    (fetch_pc),
    .fill       (fill),
    .fill_inst  (icache_resp_data_i),
    .pop        (pop),
    .wr_ptr     (wr_ptr),
    .rsp_ptr    (rsp_ptr),
    .rd_ptr     (rd_ptr),
    .head_valid (inst_valid_o),
    .head_pc    (inst_pc_o),
    .head_inst  (inst_o)
  );

  // A response with nothing outstanding means the icache lost sync with us.
  always @(posedge clk) begin
    if (!rst && icache_resp_valid_i) begin
      assert (drop_cnt != '0 || wr_ptr != rsp_ptr)
        else $error("fetch_pc_gen: unsolicited icache response");
    end
  end

endmodule
